// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and a helper that sizes the busy-window counter.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Counter must hold the longer of the two busy windows, never narrower than 4 bits.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int longest;
        int w;
        longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        w       = $clog2(longest + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 arithmetic core: signed/unsigned multiply giving a 64-bit
// product, and signed/unsigned divide giving {remainder, quotient}.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Select the arithmetic result for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        result   = '0;
        div_zero = 1'b0;
        case (md_op_e'(op))
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // Quotient overflows 32 bits; wrap to the dividend, remainder zero.
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    // Signed / and % truncate toward zero; remainder follows the dividend.
                    result = {a_s % b_s, a_s / b_s};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: latches an operation at issue,
// holds a fixed busy window, then commits the pending result into HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        busy_real,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               busy_q,  busy_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;
    logic [31:0]        p_hi_q,  p_hi_d;
    logic [31:0]        p_lo_q,  p_lo_d;
    logic               p_dz_q,  p_dz_d;

    logic [63:0]        arith_res;
    logic               arith_dz;

    mdu_arith u_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (arith_res),
        .div_zero (arith_dz)
    );

    // Next-state logic: issue in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_dz_d  = p_dz_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (md_op_e'(op))
                        MD_MULT, MD_MULTU: begin
                            {p_hi_d, p_lo_d} = arith_res;
                            p_dz_d  = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            {p_hi_d, p_lo_d} = arith_res;
                            p_dz_d  = arith_dz;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = MD_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                // Any start seen here is ignored; the stall logic keeps it from happening.
                if (cnt_q == CNT_W'(1)) begin
                    if (!p_dz_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation without committing.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge
        // values, independent of statement order.
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_dz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_dz_q  <= p_dz_d;
        end
    end

    assign busy      = busy_q;
    assign busy_real = start | busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: expected HI/LO and busy-window lengths are
// queued at issue and compared when the busy window closes.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        busy_real;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    sb_entry_t sb_q[$];
    int        busy_cnt      = 0;
    int        rr_cnt        = 0;
    int        last_rr       = 0;
    bit        abort_pending = 1'b0;

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .busy_real (busy_real),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] eh, input logic [31:0] el,
                            input int cyc);
        sb_entry_t e;
        e.tag    = tag;
        e.hi     = eh;
        e.lo     = el;
        e.cycles = cyc;
        sb_q.push_back(e);
    endtask

    // Monitor: measures busy / busy_real run lengths and scores HI/LO when busy falls.
    always @(negedge clk) begin
        sb_entry_t e;
        if (busy_real) begin
            rr_cnt++;
        end else if (rr_cnt != 0) begin
            last_rr = rr_cnt;
            rr_cnt  = 0;
        end
        if (busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
            end else if (sb_q.size() == 0) begin
                check("sb_unexpected_window", 64'(busy_cnt), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_busy_len"}, 64'(busy_cnt), 64'(e.cycles));
                check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
            end
            busy_cnt = 0;
        end
    end

    task automatic wait_busy_real_low(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy_real) done = 1'b1;
        end
        if (!done) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic do_op(input md_op_e o, input logic [31:0] av, input logic [31:0] bv,
                         input int exp_rr, input string tag);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        check({tag, "_busy_real_issue"}, 64'(busy_real), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_busy_real_low(tag);
        check({tag, "_busy_real_len"}, 64'(last_rr), 64'(exp_rr));
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_busy_real", 64'(busy_real), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        push_exp("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 6, "mult_neg");

        push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, "multu_max");

        push_exp("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 11, "div_neg");

        push_exp("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        do_op(MD_DIVU, 32'd7, 32'd0, 11, "divu_zero");

        push_exp("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 11, "div_ovf");

        do_op(MD_MTHI, 32'h1234_5678, 32'd0, 1, "mthi");
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo", 64'(lo), 64'h8000_0000);

        do_op(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1, "mtlo");
        check("mtlo_hi", 64'(hi), 64'h1234_5678);
        check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);

        do_op(md_op_e'(3'd6), 32'h5555_5555, 32'd9, 1, "bad_op");
        check("bad_op_hi", 64'(hi), 64'h1234_5678);
        check("bad_op_lo", 64'(lo), 64'hCAFE_F00D);

        // MTLO issued while a MULT is running must be dropped.
        push_exp("mult_mtlo", 32'h0000_0000, 32'h0000_002A, 5);
        @(posedge clk); #1;
        start = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_busy_real_low("mult_mtlo");
        check("mult_mtlo_busy_real_len", 64'(last_rr), 64'd6);

        // Back-to-back: DIV issued in the first cycle after MULT's busy falls.
        push_exp("b2b_mult", 32'd0, 32'd12, 5);
        push_exp("b2b_div", 32'd2, 32'd14, 10);
        @(posedge clk); #1;
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
                found = 1'b1;
            end
        end
        check("b2b_mult_done", 64'(found), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_busy_real_low("b2b");
        check("b2b_busy_real_len", 64'(last_rr), 64'd17);

        // Reset during the third busy cycle of a DIV aborts with no commit.
        @(posedge clk); #1;
        start = 1'b1; op = MD_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_pending = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (15) @(negedge clk);
        check("abort_late_busy", 64'(busy), 64'd0);
        check("abort_late_hi", 64'(hi), 64'd0);
        check("abort_late_lo", 64'(lo), 64'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
